simon_game_core: RTL and testbench

SIMON_GAME_CORE -- requirements
Module: simon_game_core

---
 rtl/simon_game_core.sv | 203 ++++++++++++++++++++
 tb/tb_simon_game_core.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/simon_game_core.sv
// Simon memory game core: LFSR sequence, LED playback, button entry.
// Single clock, synchronous active-low reset, all outputs registered.
module simon_game_core #(
  parameter int COLOUR_W       = 2,
  parameter int MAX_ROUNDS     = 16,
  parameter int HOLD_CYCLES    = 5_000_000,
  parameter int GAP_CYCLES     = 2_500_000,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  localparam int N_COLOURS     = 2**COLOUR_W,
  localparam int RW            = $clog2(MAX_ROUNDS+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           seed,
  input  logic [N_COLOURS-1:0] btn,
  output logic [N_COLOURS-1:0] led,
  output logic [2:0]           state,
  output logic [RW-1:0]        round,
  output logic                 win,
  output logic                 lose,
  output logic                 busy
);

  localparam int AW = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;
  localparam int T1M = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TMAX = (T1M > TIMEOUT_CYCLES) ? T1M : TIMEOUT_CYCLES;
  localparam int TW = $clog2(TMAX+1);

  localparam logic [TW-1:0] HOLD_END = TW'(HOLD_CYCLES-1);
  localparam logic [TW-1:0] GAP_END  = TW'(GAP_CYCLES-1);
  localparam logic [TW-1:0] TO_END   = TW'(TIMEOUT_CYCLES-1);
  localparam logic [TW-1:0] T1       = TW'(1);
  localparam logic [RW-1:0] R1       = RW'(1);
  localparam logic [RW-1:0] LAST_RND = RW'(MAX_ROUNDS);
  localparam logic [RW-1:0] GEN_END  = RW'(MAX_ROUNDS-1);
  localparam logic [N_COLOURS-1:0] ONE = N_COLOURS'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GEN      = 3'd1,
    SHOW_ON  = 3'd2,
    SHOW_OFF = 3'd3,
    INPUT    = 3'd4,
    WIN      = 3'd5,
    LOSE     = 3'd6
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             lfsr_q, lfsr_d;
  logic [RW-1:0]          round_q, round_d;
  logic [RW-1:0]          idx_q, idx_d;
  logic [TW-1:0]          tmr_q, tmr_d;
  logic [N_COLOURS-1:0]   btn_q;
  logic [N_COLOURS-1:0]   led_q, led_d;
  logic                   win_q, win_d;
  logic                   lose_q, lose_d;
  logic                   busy_q, busy_d;
  logic [COLOUR_W-1:0]    mem_q [2**AW];

  logic [7:0]             lfsr_nxt;
  logic [COLOUR_W-1:0]    cur_col, nxt_col;
  logic                   mem_we, press, btn_1h, hit, last;

  assign lfsr_nxt = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
  assign mem_we   = (state_q == GEN);
  assign cur_col  = mem_q[idx_q[AW-1:0]];
  assign press    = (|btn) & ~(|btn_q);
  assign btn_1h   = (btn != '0) && ((btn & (btn - ONE)) == '0);
  assign hit      = btn_1h && (btn == (ONE << cur_col));
  assign last     = (idx_q == (round_q - R1));

  // Forward the colour being written so a 1-round game shows it at once.
  assign nxt_col = (mem_we && idx_d[AW-1:0] == idx_q[AW-1:0])
                 ? lfsr_q[COLOUR_W-1:0]
                 : mem_q[idx_d[AW-1:0]];

  // Game sequencing: next state, LFSR, round, step index and shared timer.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    round_d = round_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      IDLE, WIN, LOSE: begin
        if (start) begin
          state_d = GEN;
          lfsr_d  = (seed == 8'h00) ? 8'h01 : seed;
          round_d = R1;
          idx_d   = '0;
          tmr_d   = '0;
        end
      end
      GEN: begin
        lfsr_d = lfsr_nxt;
        if (idx_q == GEN_END) begin
          state_d = SHOW_ON;
          idx_d   = '0;
          tmr_d   = '0;
        end else begin
          idx_d = idx_q + R1;
        end
      end
      SHOW_ON: begin
        if (tmr_q == HOLD_END) begin
          state_d = SHOW_OFF;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + T1;
        end
      end
      SHOW_OFF: begin
        if (tmr_q == GAP_END) begin
          tmr_d = '0;
          if (idx_q + R1 == round_q) begin
            state_d = INPUT;
            idx_d   = '0;
          end else begin
            state_d = SHOW_ON;
            idx_d   = idx_q + R1;
          end
        end else begin
          tmr_d = tmr_q + T1;
        end
      end
      INPUT: begin
        if (press) begin
          tmr_d = '0;
          if (!hit) begin
            state_d = LOSE;
          end else if (last && round_q == LAST_RND) begin
            state_d = WIN;
          end else if (last) begin
            state_d = SHOW_ON;
            round_d = round_q + R1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + R1;
          end
        end else if (tmr_q == TO_END) begin
          state_d = LOSE;
        end else begin
          tmr_d = tmr_q + T1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the state being entered, so outputs are registered.
  always_comb begin
    led_d  = '0;
    win_d  = (state_d == WIN);
    lose_d = (state_d == LOSE);
    busy_d = state_d inside {GEN, SHOW_ON, SHOW_OFF, INPUT};
    case (state_d)
      SHOW_ON: led_d = ONE << nxt_col;
      INPUT:   led_d = btn_1h ? btn : '0;
      default: led_d = '0;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= '0;
      round_q <= '0;
      idx_q   <= '0;
      tmr_q   <= '0;
      btn_q   <= '0;
      led_q   <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      round_q <= round_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      btn_q   <= btn;
      led_q   <= led_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      busy_q  <= busy_d;
    end
  end

  // Sequence memory, fully rewritten in GEN so it needs no reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q[AW-1:0]] <= lfsr_q[COLOUR_W-1:0];
  end

  assign led   = led_q;
  assign state = state_q;
  assign round = round_q;
  assign win   = win_q;
  assign lose  = lose_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_simon_game_core.sv
// Directed bench for simon_game_core with an expected-output queue.
// Seed 0x01 gives colour sequence 1,0 (led 0010 then 0001).
module tb_simon_game_core;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GEN  = 3'd1;
  localparam logic [2:0] S_ON   = 3'd2;
  localparam logic [2:0] S_OFF  = 3'd3;
  localparam logic [2:0] S_IN   = 3'd4;
  localparam logic [2:0] S_WIN  = 3'd5;
  localparam logic [2:0] S_LOSE = 3'd6;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [7:0] seed;
  logic [3:0] btn, led;
  logic [2:0] state;
  logic [1:0] round;
  logic       win, lose, busy;

  always #5 clk = ~clk;

  simon_game_core #(
    .COLOUR_W(2),
    .MAX_ROUNDS(2),
    .HOLD_CYCLES(4),
    .GAP_CYCLES(2),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .seed(seed),
    .btn(btn),
    .led(led),
    .state(state),
    .round(round),
    .win(win),
    .lose(lose),
    .busy(busy)
  );

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [3:0] led;
    logic [1:0] rnd;
    bit         led_chk;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check_out();
    exp_t e;
    logic ew, el, eb;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard empty: got state %0d want an entry", state);
      return;
    end
    e  = sb.pop_front();
    ew = (e.st == S_WIN);
    el = (e.st == S_LOSE);
    eb = (e.st inside {S_GEN, S_ON, S_OFF, S_IN});
    checks++;
    assert (state === e.st) else begin
      errors++;
      $error("FAIL %s state: got %0d want %0d", e.tag, state, e.st);
    end
    checks++;
    assert (round === e.rnd) else begin
      errors++;
      $error("FAIL %s round: got %0d want %0d", e.tag, round, e.rnd);
    end
    checks++;
    assert (win === ew) else begin
      errors++;
      $error("FAIL %s win: got %b want %b", e.tag, win, ew);
    end
    checks++;
    assert (lose === el) else begin
      errors++;
      $error("FAIL %s lose: got %b want %b", e.tag, lose, el);
    end
    checks++;
    assert (busy === eb) else begin
      errors++;
      $error("FAIL %s busy: got %b want %b", e.tag, busy, eb);
    end
    if (e.led_chk) begin
      checks++;
      assert (led === e.led) else begin
        errors++;
        $error("FAIL %s led: got %b want %b", e.tag, led, e.led);
      end
    end
  endtask

  // Push the expectation for the coming edge, then compare after it.
  task automatic cyc(input int n, input string tag,
                     input logic [2:0] st, input logic [3:0] l,
                     input logic [1:0] r, input bit lc);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.tag     = tag;
      e.st      = st;
      e.led     = l;
      e.rnd     = r;
      e.led_chk = lc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out();
    end
  endtask

  // Start pulse plus GEN and the round-1 display of colour 1.
  task automatic game_to_input(input logic [7:0] sd, input string tag);
    seed  = sd;
    start = 1'b1;
    cyc(1, tag, S_GEN, 4'b0000, 2'd1, 1);
    start = 1'b0;
    cyc(1, tag, S_GEN, 4'b0000, 2'd1, 1);
    cyc(4, tag, S_ON, 4'b0010, 2'd1, 1);
    cyc(2, tag, S_OFF, 4'b0000, 2'd1, 1);
    cyc(1, tag, S_IN, 4'b0000, 2'd1, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    seed  = 8'h00;
    btn   = 4'b0000;
    cyc(2, "reset", S_IDLE, 4'b0000, 2'd0, 1);
    rst_n = 1'b1;
    cyc(1, "idle", S_IDLE, 4'b0000, 2'd0, 1);

    // Full win through both rounds.
    game_to_input(8'h01, "win_r1");
    btn = 4'b0010;
    cyc(1, "win_adv", S_ON, 4'b0010, 2'd2, 1);
    btn = 4'b0000;
    cyc(3, "win_on1", S_ON, 4'b0010, 2'd2, 1);
    cyc(2, "win_off1", S_OFF, 4'b0000, 2'd2, 1);
    cyc(4, "win_on2", S_ON, 4'b0001, 2'd2, 1);
    cyc(2, "win_off2", S_OFF, 4'b0000, 2'd2, 1);
    cyc(1, "win_in2", S_IN, 4'b0000, 2'd2, 1);
    btn = 4'b0010;
    cyc(1, "win_p1", S_IN, 4'b0010, 2'd2, 1);
    btn = 4'b0000;
    cyc(1, "win_rel", S_IN, 4'b0000, 2'd2, 1);
    btn = 4'b0001;
    cyc(1, "win", S_WIN, 4'b0000, 2'd2, 1);
    btn = 4'b0000;
    cyc(3, "win_stick", S_WIN, 4'b0000, 2'd2, 1);

    // start held through GEN/SHOW/INPUT is ignored; then a wrong colour.
    seed  = 8'h01;
    start = 1'b1;
    cyc(2, "ign_gen", S_GEN, 4'b0000, 2'd1, 1);
    cyc(4, "ign_on", S_ON, 4'b0010, 2'd1, 1);
    cyc(2, "ign_off", S_OFF, 4'b0000, 2'd1, 1);
    cyc(3, "ign_in", S_IN, 4'b0000, 2'd1, 1);
    start = 1'b0;
    btn   = 4'b0100;
    cyc(1, "wrong", S_LOSE, 4'b0000, 2'd1, 1);
    btn = 4'b0000;
    cyc(2, "lose_stick", S_LOSE, 4'b0000, 2'd1, 1);

    // Seed 0x00 behaves as 0x01; two buttons at once loses.
    game_to_input(8'h00, "seed0");
    btn = 4'b0011;
    cyc(1, "multi", S_LOSE, 4'b0000, 2'd1, 1);
    btn = 4'b0000;

    // Button held from SHOW_OFF into INPUT is not a press.
    seed  = 8'h01;
    start = 1'b1;
    cyc(1, "hold_gen", S_GEN, 4'b0000, 2'd1, 1);
    start = 1'b0;
    cyc(1, "hold_gen", S_GEN, 4'b0000, 2'd1, 1);
    cyc(4, "hold_on", S_ON, 4'b0010, 2'd1, 1);
    cyc(1, "hold_off", S_OFF, 4'b0000, 2'd1, 1);
    btn = 4'b0010;
    cyc(1, "hold_off", S_OFF, 4'b0000, 2'd1, 1);
    cyc(1, "hold_in0", S_IN, 4'b0000, 2'd1, 0);
    cyc(19, "hold_in", S_IN, 4'b0010, 2'd1, 1);
    cyc(1, "hold_to", S_LOSE, 4'b0000, 2'd1, 1);
    btn = 4'b0000;

    // Valid press on the last allowed cycle wins over the timeout.
    game_to_input(8'h01, "tmo");
    cyc(19, "tmo_wait", S_IN, 4'b0000, 2'd1, 1);
    btn = 4'b0010;
    cyc(1, "tmo_edge", S_ON, 4'b0010, 2'd2, 1);
    btn = 4'b0000;
    cyc(3, "tmo_on1", S_ON, 4'b0010, 2'd2, 1);
    cyc(2, "tmo_off1", S_OFF, 4'b0000, 2'd2, 1);
    cyc(4, "tmo_on2", S_ON, 4'b0001, 2'd2, 1);
    cyc(2, "tmo_off2", S_OFF, 4'b0000, 2'd2, 1);
    cyc(20, "tmo_idle", S_IN, 4'b0000, 2'd2, 1);
    cyc(1, "tmo_lose", S_LOSE, 4'b0000, 2'd2, 1);

    // Reset in the middle of SHOW_ON.
    seed  = 8'h01;
    start = 1'b1;
    cyc(1, "rst_gen", S_GEN, 4'b0000, 2'd1, 1);
    start = 1'b0;
    cyc(1, "rst_gen", S_GEN, 4'b0000, 2'd1, 1);
    cyc(2, "rst_on", S_ON, 4'b0010, 2'd1, 1);
    rst_n = 1'b0;
    cyc(1, "rst_mid", S_IDLE, 4'b0000, 2'd0, 1);
    rst_n = 1'b1;
    cyc(2, "rst_post", S_IDLE, 4'b0000, 2'd0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
